pipeline_hazard_ctrl: RTL

- Central hazard/sequencing controller for the 5-stage RV32I pipeline.
- Drives write-enable and flush of the IF/ID register, PC write-enable, ID/EX bubble insertion and a global hold for later stages.
- Resolves load-use hazards, EX-stage taken branches/jumps, and instruction/data memory wait states.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/sat_counter.sv | 31 +++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: hazard inputs in, stage enables and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipeline_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] idRs1;
  logic [REG_IDX_W-1:0] idRs2;
  logic                 idUsesRs1;
  logic                 idUsesRs2;
  logic [REG_IDX_W-1:0] exRd;
  logic                 exMemRead;
  logic                 branchTaken;
  logic                 imemReady;
  logic                 dmemBusy;

  logic                 pcWrite;
  logic                 ifIdWrite;
  logic                 ifIdFlush;
  logic                 idExFlush;
  logic                 pipeHold;
  logic [CNT_W-1:0]     stallCount;
  logic [CNT_W-1:0]     flushCount;

  modport master (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemRead,
           branchTaken, imemReady, dmemBusy,
    input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeHold,
           stallCount, flushCount
  );

  modport slave (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemRead,
           branchTaken, imemReady, dmemBusy,
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeHold,
           stallCount, flushCount
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use stalls,
// taken-branch flushes, memory wait states and stall/flush performance counters.
//
// state    | meaning
// RUN      | normal issue; load-use and fetch-wait handled here
// FLUSH    | extra IF/ID flush cycles after a taken branch, flush_left remaining
// MEM_WAIT | pipeline frozen on data memory; branch_pending remembers a branch seen meanwhile
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   hz
);

  localparam logic [2:0] FLUSH_INIT = 3'(BRANCH_PENALTY - 1);

  hazard_state_t state_q, state_d;
  logic [2:0]    flush_left_q, flush_left_d;
  logic          branch_pending_q, branch_pending_d;

  logic load_use;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
  logic [CNT_W-1:0] stall_count, flush_count;

  assign load_use = hz.exMemRead && (hz.exRd != X0_IDX) &&
                    ((hz.idUsesRs1 && (hz.idRs1 == hz.exRd)) ||
                     (hz.idUsesRs2 && (hz.idRs2 == hz.exRd)));

  always_comb begin
    state_d          = state_q;
    flush_left_d     = flush_left_q;
    branch_pending_d = branch_pending_q;
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    if_id_flush      = 1'b0;
    id_ex_flush      = 1'b0;
    pipe_hold        = 1'b0;

    if (hz.dmemBusy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
      if (hz.branchTaken) begin
        branch_pending_d = 1'b1;
      end
      state_d = MEM_WAIT;
    end else if (hz.branchTaken || ((state_q == MEM_WAIT) && branch_pending_q)) begin
      // Branch wins over load-use: the stalled ID instruction is on the wrong path.
      if_id_flush      = 1'b1;
      id_ex_flush      = 1'b1;
      branch_pending_d = 1'b0;
      if (BRANCH_PENALTY > 1) begin
        state_d      = FLUSH;
        flush_left_d = FLUSH_INIT;
      end else begin
        state_d      = RUN;
        flush_left_d = '0;
      end
    end else if (state_q == FLUSH) begin
      if_id_flush  = 1'b1;
      flush_left_d = flush_left_q - 3'd1;
      if (flush_left_q <= 3'd1) begin
        state_d      = RUN;
        flush_left_d = '0;
      end
    end else begin
      state_d = RUN;
      if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!hz.imemReady) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      flush_left_q     <= '0;
      branch_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_left_q     <= flush_left_d;
      branch_pending_q <= branch_pending_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!rst && !pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!rst && if_id_flush),
    .count (flush_count)
  );

  assign hz.pcWrite    = pc_write;
  assign hz.ifIdWrite  = if_id_write;
  assign hz.ifIdFlush  = if_id_flush;
  assign hz.idExFlush  = id_ex_flush;
  assign hz.pipeHold   = pipe_hold;
  assign hz.stallCount = stall_count;
  assign hz.flushCount = flush_count;

endmodule
